// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one synchronous DM port between the CPU and a debug port.
// Optional debug starvation guard: define ARB_STARVE_GUARD_EN.
module dm_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int CW = $clog2(RD_LAT + 1);

    if (RD_LAT < 1 || STARVE_MAX < 1) begin : g_param_check
        $error("dm_port_arbiter: RD_LAT and STARVE_MAX must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state, state_n;
    logic          owner, owner_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          cpu_gnt_n, dbg_gnt_n;
    logic          cpu_rvalid_n, dbg_rvalid_n;
    logic          mem_en_n, mem_we_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n, rdata_n;
    logic          pick_dbg;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt, starve_cnt_n;

    // A saturated counter hands the next slot to a waiting debug request.
    assign pick_dbg = dbg_req && (!cpu_req || starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        starve_cnt_n = starve_cnt;
        if (state == IDLE && (cpu_req || dbg_req)) begin
            if (dbg_req && !pick_dbg) starve_cnt_n = starve_cnt + SW'(1);
            else starve_cnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt <= '0;
        else starve_cnt <= starve_cnt_n;
    end
`else
    assign pick_dbg = dbg_req && !cpu_req;
`endif

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        cnt_n        = cnt;
        mem_en_n     = 1'b0;
        mem_we_n     = 1'b0;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        rdata_n      = rdata;
        cpu_gnt_n    = 1'b0;
        dbg_gnt_n    = 1'b0;
        cpu_rvalid_n = 1'b0;
        dbg_rvalid_n = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    owner_n     = pick_dbg;
                    mem_en_n    = 1'b1;
                    mem_we_n    = pick_dbg ? dbg_we : cpu_we;
                    mem_addr_n  = pick_dbg ? dbg_addr : cpu_addr;
                    mem_wdata_n = pick_dbg ? dbg_wdata : cpu_wdata;
                    cpu_gnt_n   = !pick_dbg;
                    dbg_gnt_n   = pick_dbg;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_we) begin
                    state_n = IDLE;
                end else begin
                    cnt_n   = CW'(RD_LAT);
                    state_n = WAIT;
                end
            end
            WAIT: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    rdata_n      = mem_rdata;
                    cpu_rvalid_n = !owner;
                    dbg_rvalid_n = owner;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            cnt        <= cnt_n;
            busy       <= (state_n != IDLE);
            mem_en     <= mem_en_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            rdata      <= rdata_n;
            cpu_gnt    <= cpu_gnt_n;
            dbg_gnt    <= dbg_gnt_n;
            cpu_rvalid <= cpu_rvalid_n;
            dbg_rvalid <= dbg_rvalid_n;
        end
    end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single synchronous data-memory (DM) port between two requesters: the CPU datapath (load/store) and a debug/loader port, used for program and data upload and inspection.
- Sits between the CU-driven datapath and DM.
- Sequences each access through issue and read-latency wait, and returns read data with a valid pulse.
- Strict CPU priority by default; an optional starvation guard is available.

Parameters:
- AW, 8, address width forwarded to DM.
- DW, 32, data width.
- RD_LAT, 1, DM read latency in cycles (>=1), counted from the edge that samples the address to valid mem_rdata.
- STARVE_MAX, 4, consecutive CPU grants tolerated while dbg_req is pending (used only with ARB_STARVE_GUARD_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request, held until cpu_gnt.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU command issued.
- cpu_rvalid  out  1  one-cycle pulse: rdata valid for CPU read.
- dbg_req  in  1  debug access request, held until dbg_gnt.
- dbg_we  in  1  1=write, 0=read.
- dbg_addr  in  AW  debug address.
- dbg_wdata  in  DW  debug write data.
- dbg_gnt  out  1  one-cycle pulse: debug command issued.
- dbg_rvalid  out  1  one-cycle pulse: rdata valid for debug read.
- rdata  out  DW  captured read data, shared; qualified by *_rvalid.
- busy  out  1  high whenever state != IDLE.
- mem_en  out  1  DM access strobe.
- mem_we  out  1  DM write enable.
- mem_addr  out  AW  DM address.
- mem_wdata  out  DW  DM write data.
- mem_rdata  in  DW  DM read data.

Behaviour:
- Clocking and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE. All outputs 0: gnt, rvalid, rdata, mem_*, busy. Owner=CPU. Counters=0.
- States: IDLE, ISSUE, WAIT.
- All outputs are registered. No combinational path from req/addr to mem_*.
- IDLE:
  - Requests are sampled only in IDLE.
  - If cpu_req or dbg_req is high, select the winner. CPU wins on a tie (guard overrides, see Optional Feature).
  - Register the winner's we, addr and wdata into mem_we, mem_addr, mem_wdata. Set mem_en=1, set that requester's gnt=1, record the owner, go to ISSUE.
  - With no request, stay in IDLE with mem_en=0.
- ISSUE (one cycle):
  - mem_en, mem_we, mem_addr, mem_wdata and gnt are high/valid for exactly this cycle; DM samples them at the closing edge.
  - On that edge, clear mem_en, mem_we and gnt. mem_addr/mem_wdata hold their value (no toggling needed).
  - Write: go to IDLE.
  - Read: load the wait counter with RD_LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the edge where counter==1: capture mem_rdata into rdata, pulse the owner's rvalid for the next cycle, go to IDLE.
- Timing (request high in cycle 0):
  - Write: gnt in cycle 1; new request accepted in cycle 2.
  - Read: gnt in cycle 1, rvalid in cycle RD_LAT+2. A new request is accepted in that same cycle (rvalid and new-issue selection overlap).
- rdata holds its value until the next read capture. Writes do not modify rdata.
- Requester protocol:
  - Command fields must be stable while req is high.
  - A requester drops req in the cycle after it sees gnt. A req still high in the IDLE after gnt is treated as a new access.
  - A requester may withdraw req before gnt. The arbiter ignores it because sampling happens only in IDLE.
- The loser of a tie keeps waiting and is re-arbitrated at the next IDLE.
- Reset mid-transaction: the in-flight access is dropped. No gnt/rvalid is produced afterwards; mem_en is forced to 0 immediately (asynchronous).
- Address and data pass through unmodified; no alignment checking.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - starve_cnt (width clog2(STARVE_MAX+1)) increments on each IDLE selection where the CPU wins while dbg_req is high.
  - When starve_cnt==STARVE_MAX and dbg_req is high at selection, debug wins even if cpu_req is high, and starve_cnt clears.
  - starve_cnt also clears on any debug grant, and on any selection with dbg_req low.
- Not defined: strict CPU priority; debug can starve indefinitely; no counter logic.

Test Plan:
- CPU write: cpu_req=1, we=1, addr=0x10, wdata=0xDEADBEEF at cycle 0 -> cycle 1 has cpu_gnt=1, mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; busy=0 in cycle 2.
- CPU read, RD_LAT=1: model returns 0x12345678 for addr 0x10 -> cpu_gnt in cycle 1, cpu_rvalid=1 with rdata=0x12345678 in cycle 3, dbg_rvalid stays 0. Repeat with RD_LAT=3 -> rvalid in cycle 5.
- Tie: cpu_req and dbg_req both high in cycle 0, both writes -> cpu_gnt in cycle 1, dbg_gnt in cycle 3, mem_addr switches to dbg_addr in cycle 3.
- Starvation, macro on, STARVE_MAX=4: cpu_req held continuously (re-raised each IDLE) plus dbg_req high -> 4 cpu_gnt pulses, then dbg_gnt on the 5th issue. Macro off -> dbg_gnt never occurs while cpu_req is continuously high.
- Reset mid-read: assert rst_n=0 during WAIT -> mem_en, gnt, rvalid and rdata read 0 immediately; after release, no rvalid appears and state is IDLE.
- Withdraw: dbg_req high for 1 cycle while busy with a CPU read, then low -> no dbg_gnt ever issued.
